// File: rtl/fix_bodylength_checker_pkg.sv
// Shared constants, error codes and FSM states for the inbound
// FIX BodyLength checker.
package fix_bodylength_checker_pkg;

    localparam logic [7:0] SOH     = 8'h01;
    localparam logic [7:0] EQ      = 8'h3D;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] TAG9    = 8'h39;
    localparam logic [7:0] TAG10_1 = 8'h31;
    localparam logic [7:0] TAG10_0 = 8'h30;

    typedef logic [2:0] err_t;

    localparam err_t ERR_NONE    = 3'd0;
    localparam err_t ERR_HDR     = 3'd1;
    localparam err_t ERR_DIGIT   = 3'd2;
    localparam err_t ERR_OVF     = 3'd3;
    localparam err_t ERR_NOSOH   = 3'd4;
    localparam err_t ERR_TRAILER = 3'd5;
    localparam err_t ERR_EMPTY   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_T9A,
        S_T9B,
        S_DIG,
        S_BODY,
        S_TRL,
        S_FAIL
    } state_t;

    // Expected byte at each position of the "10=" trailer tag
    function automatic logic [7:0] trl_char(input logic [1:0] pos);
        logic [7:0] c;
        c = EQ;
        unique case (1'b1)
            (pos == 2'd0): c = TAG10_1;
            (pos == 2'd1): c = TAG10_0;
            default:       c = EQ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fix_bodylength_checker_ascii_to_bin_accum.sv
// ASCII decimal accumulator: digit detect, acc*10+d, digit count
// and overflow (too many digits or value beyond LEN_WIDTH bits).
module fix_bodylength_checker_ascii_to_bin_accum
    import fix_bodylength_checker_pkg::*;
#(
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_DIGITS = 5,
    parameter int DW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic [7:0]           byte_i,
    output logic                 is_digit,
    output logic                 ovf,
    output logic [LEN_WIDTH-1:0] acc,
    output logic [DW-1:0]        ndig
);

    localparam int AW = LEN_WIDTH + 4;
    localparam logic [AW-1:0] LIMIT = AW'({LEN_WIDTH{1'b1}});

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_nxt;
    logic [DW-1:0] ndig_q;

    assign is_digit = (byte_i >= ZERO) && (byte_i <= ZERO + 8'd9);
    assign acc_nxt  = acc_q * AW'(10) + AW'(byte_i[3:0]);
    assign ovf      = is_digit &&
                      ((ndig_q == DW'(MAX_DIGITS)) || (acc_nxt > LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            ndig_q <= '0;
        end else if (clear) begin
            acc_q  <= '0;
            ndig_q <= '0;
        end else if (step) begin
            acc_q  <= acc_nxt;
            ndig_q <= ndig_q + DW'(1);
        end
    end

    assign acc  = acc_q[LEN_WIDTH-1:0];
    assign ndig = ndig_q;

endmodule

// File: rtl/fix_bodylength_checker.sv
// Inbound FIX BodyLength checker: parses tag 9, counts body bytes
// and verifies the stream lands exactly on the "10=" trailer.
module fix_bodylength_checker
    import fix_bodylength_checker_pkg::*;
#(
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic [LEN_WIDTH-1:0] body_length_o,
    output logic                 length_valid_o,
    output logic                 body_byte_o,
    output logic                 done_o,
    output logic                 match_o,
    output logic [2:0]           error_o
);

    localparam int DW = $clog2(MAX_DIGITS + 1);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           tpos_q, tpos_d;
    logic [LEN_WIDTH-1:0] len_d;
    logic                 lv_d, bb_d, done_d, match_d;
    err_t                 err_d;
    logic                 fail;
    err_t                 code;

    logic                 acc_clear, acc_step;
    logic                 is_digit, ovf;
    logic [LEN_WIDTH-1:0] acc;
    logic [DW-1:0]        ndig;

    fix_bodylength_checker_ascii_to_bin_accum #(
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .DW         (DW)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .step     (acc_step),
        .byte_i   (byte_i),
        .is_digit (is_digit),
        .ovf      (ovf),
        .acc      (acc),
        .ndig     (ndig)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tpos_d    = tpos_q;
        len_d     = body_length_o;
        lv_d      = 1'b0;
        bb_d      = 1'b0;
        done_d    = 1'b0;
        match_d   = 1'b0;
        err_d     = ERR_NONE;
        fail      = 1'b0;
        code      = ERR_NONE;
        acc_clear = 1'b0;
        acc_step  = 1'b0;
        if (byte_valid_i && start_i) begin
            // New message wins over whatever was in flight
            state_d   = S_HDR;
            cnt_d     = '0;
            tpos_d    = '0;
            len_d     = '0;
            acc_clear = 1'b1;
        end else if (byte_valid_i) begin
            unique case (state_q)
                S_IDLE, S_FAIL: state_d = S_IDLE;
                S_HDR: begin
                    if (byte_i == SOH) state_d = S_T9A;
                end
                S_T9A: begin
                    if (byte_i == TAG9) state_d = S_T9B;
                    else begin
                        fail = 1'b1;
                        code = ERR_HDR;
                    end
                end
                S_T9B: begin
                    if (byte_i == EQ) state_d = S_DIG;
                    else begin
                        fail = 1'b1;
                        code = ERR_HDR;
                    end
                end
                S_DIG: begin
                    if (is_digit) begin
                        if (ovf) begin
                            fail = 1'b1;
                            code = ERR_OVF;
                        end else begin
                            acc_step = 1'b1;
                        end
                    end else if (byte_i == SOH) begin
                        if (ndig == '0) begin
                            fail = 1'b1;
                            code = ERR_EMPTY;
                        end else begin
                            len_d   = acc;
                            lv_d    = 1'b1;
                            cnt_d   = acc;
                            tpos_d  = '0;
                            state_d = (acc == '0) ? S_TRL : S_BODY;
                        end
                    end else begin
                        fail = 1'b1;
                        code = ERR_DIGIT;
                    end
                end
                S_BODY: begin
                    bb_d  = 1'b1;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        if (byte_i == SOH) begin
                            state_d = S_TRL;
                            tpos_d  = '0;
                        end else begin
                            fail = 1'b1;
                            code = ERR_NOSOH;
                        end
                    end
                end
                S_TRL: begin
                    if (byte_i != trl_char(tpos_q)) begin
                        fail = 1'b1;
                        code = ERR_TRAILER;
                    end else if (tpos_q == 2'd2) begin
                        done_d  = 1'b1;
                        match_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tpos_d = tpos_q + 2'd1;
                    end
                end
            endcase
            if (fail) begin
                state_d = S_FAIL;
                done_d  = 1'b1;
                err_d   = code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            tpos_q         <= '0;
            body_length_o  <= '0;
            length_valid_o <= 1'b0;
            body_byte_o    <= 1'b0;
            done_o         <= 1'b0;
            match_o        <= 1'b0;
            error_o        <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tpos_q         <= tpos_d;
            body_length_o  <= len_d;
            length_valid_o <= lv_d;
            body_byte_o    <= bb_d;
            done_o         <= done_d;
            match_o        <= match_d;
            error_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_fix_bodylength_checker.sv
// Scoreboard bench for fix_bodylength_checker: expected length and
// done results are queued as bytes are driven, popped on DUT pulses.
module tb_fix_bodylength_checker;

    localparam int LW = 16;
    localparam int NC = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [7:0]    byte_i = 8'h00;
    logic          byte_valid_i = 1'b0;
    logic [LW-1:0] body_length_o;
    logic          length_valid_o;
    logic          body_byte_o;
    logic          done_o;
    logic          match_o;
    logic [2:0]    error_o;

    int n_cmp = 0;
    int n_fail = 0;
    int bb_cnt = 0;

    logic [LW-1:0] exp_len_q[$];
    logic [3:0]    exp_done_q[$];

    // '|' stands for SOH in these message strings
    string msg [NC] = '{
        "8=FIX.4.2|9=5|35=0|10=123|",
        "8=FIX.4.2|9=6|35=0|10=123|",
        "8=FIX.4.2|9=4|35=0|10=123|",
        "8=FIX.4.2|9=0|35=0|10=123|",
        "8=FIX.4.2|9=12a|",
        "8=FIX.4.2|9=123456|",
        "8=FIX.4.2|9=70000|",
        "8=FIX.4.2|9=65535|",
        "8=FIX.4.2|9=|",
        "8=FIX.4.2|35=0|",
        "8=FIX.4.2|9=0|10=|",
        "8=FIX.4.2|9=005|35=0|10=1|"
    };
    bit      c_hl [NC] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1};
    int      c_ln [NC] = '{5, 6, 4, 0, 0, 0, 0, 65535, 0, 0, 0, 5};
    bit      c_hd [NC] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    bit      c_mt [NC] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int      c_er [NC] = '{0, 4, 4, 5, 2, 3, 3, 0, 6, 1, 0, 0};
    int      c_bb [NC] = '{5, 6, 4, 0, 0, 0, 0, 0, 0, 0, 0, 5};

    always #5 clk = ~clk;

    fix_bodylength_checker #(
        .LEN_WIDTH  (LW),
        .MAX_DIGITS (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .body_length_o  (body_length_o),
        .length_valid_o (length_valid_o),
        .body_byte_o    (body_byte_o),
        .done_o         (done_o),
        .match_o        (match_o),
        .error_o        (error_o)
    );

    // One clock; outputs sampled 1 ns after the edge and scored
    task automatic tick();
        logic [LW-1:0] el;
        logic [3:0]    ed;
        @(posedge clk);
        #1;
        if (length_valid_o) begin
            n_cmp++;
            if (exp_len_q.size() == 0) begin
                n_fail++;
                $display("FAIL len_unexpected got=%0d", body_length_o);
            end else begin
                el = exp_len_q.pop_front();
                if (body_length_o !== el) begin
                    n_fail++;
                    $display("FAIL body_length got=%0d exp=%0d",
                             body_length_o, el);
                end
            end
        end
        if (done_o) begin
            n_cmp++;
            if (exp_done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected match=%0b err=%0d",
                         match_o, error_o);
            end else begin
                ed = exp_done_q.pop_front();
                if ({match_o, error_o} !== ed) begin
                    n_fail++;
                    $display("FAIL done_result got m=%0b e=%0d exp m=%0b e=%0d",
                             match_o, error_o, ed[3], ed[2:0]);
                end
            end
        end
        if (body_byte_o) bb_cnt++;
        byte_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st);
        byte_i = b;
        start_i = st;
        byte_valid_i = 1'b1;
        tick();
    endtask

    task automatic send_str(input string m, input bit st, input bit gaps);
        logic [7:0] b;
        for (int i = 0; i < m.len(); i++) begin
            b = m[i];
            if (b == 8'h7C) b = 8'h01;
            send_byte(b, st && (i == 0));
            if (gaps) begin
                tick();
                n_cmp++;
                if ({length_valid_o, body_byte_o, done_o} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL gap_pulse got=%b exp=000",
                             {length_valid_o, body_byte_o, done_o});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({body_length_o, length_valid_o, body_byte_o,
             done_o, match_o, error_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs len=%0d lv=%0b bb=%0b d=%0b m=%0b e=%0d exp all 0",
                     body_length_o, length_valid_o, body_byte_o,
                     done_o, match_o, error_o);
        end
        #2 rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_messages();
        for (int i = 0; i < NC; i++) begin
            bb_cnt = 0;
            if (c_hl[i]) exp_len_q.push_back(LW'(c_ln[i]));
            if (c_hd[i]) exp_done_q.push_back({c_mt[i], 3'(c_er[i])});
            send_str(msg[i], 1'b1, 1'b0);
            repeat (3) tick();
            n_cmp++;
            if (bb_cnt != c_bb[i] || exp_len_q.size() != 0 ||
                exp_done_q.size() != 0) begin
                n_fail++;
                $display("FAIL msg%0d bb=%0d exp_bb=%0d len_left=%0d done_left=%0d exp 0",
                         i, bb_cnt, c_bb[i], exp_len_q.size(),
                         exp_done_q.size());
                exp_len_q.delete();
                exp_done_q.delete();
            end
        end
    endtask

    task automatic test_gaps();
        bb_cnt = 0;
        exp_len_q.push_back(LW'(5));
        exp_done_q.push_back({1'b1, 3'd0});
        send_str(msg[0], 1'b1, 1'b1);
        repeat (3) tick();
        n_cmp++;
        if (bb_cnt != 5 || exp_len_q.size() != 0 ||
            exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL gaps bb=%0d exp_bb=5 len_left=%0d done_left=%0d",
                     bb_cnt, exp_len_q.size(), exp_done_q.size());
            exp_len_q.delete();
            exp_done_q.delete();
        end
    endtask

    task automatic test_reset_mid_body();
        exp_len_q.push_back(LW'(5));
        send_str("8=FIX.4.2|9=5|35", 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({body_length_o, length_valid_o, body_byte_o,
             done_o, match_o, error_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs len=%0d d=%0b exp all 0",
                     body_length_o, done_o);
        end
        repeat (3) tick();
        #2 rst = 1'b1;
        tick();
        bb_cnt = 0;
        exp_len_q.push_back(LW'(5));
        exp_done_q.push_back({1'b1, 3'd0});
        send_str(msg[0], 1'b1, 1'b0);
        repeat (3) tick();
        n_cmp++;
        if (bb_cnt != 5 || exp_len_q.size() != 0 ||
            exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_reset bb=%0d exp_bb=5 len_left=%0d done_left=%0d",
                     bb_cnt, exp_len_q.size(), exp_done_q.size());
            exp_len_q.delete();
            exp_done_q.delete();
        end
    endtask

    task automatic test_start_abort();
        exp_len_q.push_back(LW'(5));
        send_str("8=FIX.4.2|9=5|35", 1'b1, 1'b0);
        send_byte(8'h38, 1'b1);
        n_cmp++;
        if (body_length_o !== '0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear len=%0d done=%0b exp len=0 done=0",
                     body_length_o, done_o);
        end
        bb_cnt = 0;
        exp_len_q.push_back(LW'(5));
        exp_done_q.push_back({1'b1, 3'd0});
        send_str("=FIX.4.2|9=5|35=0|10=123|", 1'b0, 1'b0);
        repeat (3) tick();
        n_cmp++;
        if (bb_cnt != 5 || exp_len_q.size() != 0 ||
            exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_abort bb=%0d exp_bb=5 len_left=%0d done_left=%0d",
                     bb_cnt, exp_len_q.size(), exp_done_q.size());
            exp_len_q.delete();
            exp_done_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_messages();
        test_gaps();
        test_reset_mid_body();
        test_start_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
